taylor_series_cos: RTL and testbench

- Fixed-point cosine engine. Evaluates the 8th-order Maclaurin series of cos(x) for an unsigned Q2.10 angle in radians.
- Uses a start/ready handshake.
- Sits as a compute slave in the FPGA datapath: a controller loads angle_in, pulses start, and waits for ready_out before reading cos_out.
- Multi-cycle iterative design with one shared multiplier (Horner evaluation).

---
 rtl/taylor_series_cos_pkg.sv | 40 ++++
 rtl/taylor_series_cos_if.sv | 33 +++
 rtl/taylor_series_cos_mul_shift.sv | 27 ++
 rtl/taylor_series_cos.sv | 112 +++++++++++
 tb/tb_taylor_series_cos.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/taylor_series_cos_pkg.sv
// rtl/taylor_series_cos_pkg.sv - shared types and Q-format constants for the cosine engine
//
// Purpose: FSM state type, I/O and internal fixed-point widths, and the
//          Maclaurin coefficients of cos(x) in signed Q(IW-IFRAC).IFRAC.
// Ports:   none (package).

package taylor_series_pkg;

  localparam int W     = 12;  // I/O width, Q2.10
  localparam int FRAC  = 10;  // I/O fractional bits
  localparam int IW    = 24;  // internal signed width
  localparam int IFRAC = 20;  // internal fractional bits

  localparam int ONE_Q2_10 = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SQUARE,
    ST_HORNER,
    ST_DONE
  } state_t;

  // Coefficients of x^(2n), scaled by 2^IFRAC and rounded to nearest.
  localparam logic signed [IW-1:0] C0 =  24'sd1048576;  //  1
  localparam logic signed [IW-1:0] C2 = -24'sd524288;   // -1/2
  localparam logic signed [IW-1:0] C4 =  24'sd43691;    //  1/24
  localparam logic signed [IW-1:0] C6 = -24'sd1456;     // -1/720
  localparam logic signed [IW-1:0] C8 =  24'sd26;       //  1/40320

  // Horner coefficient for each step after the C8 seed.
  function automatic logic signed [IW-1:0] horner_coef(input logic [1:0] step);
    case (step)
      2'd0:    return C6;
      2'd1:    return C4;
      2'd2:    return C2;
      default: return C0;
    endcase
  endfunction

endpackage

// File: rtl/taylor_series_cos_if.sv
// rtl/taylor_series_cos_if.sv - start/ready request bus between controller and cosine engine
//
// Purpose: groups the request/result signals of the cosine engine.
// Signals: start     - controller requests a computation
//          angle_in  - unsigned Q2.10 angle in radians
//          ready_out - engine holds a valid result
//          cos_out   - unsigned Q2.10 cosine result
// Modports: master (controller side), slave (engine side).

interface taylor_series_cos_if #(
  parameter int W = 12
) ();

  logic         start;
  logic [W-1:0] angle_in;
  logic         ready_out;
  logic [W-1:0] cos_out;

  modport master (
    output start,
    output angle_in,
    input  ready_out,
    input  cos_out
  );

  modport slave (
    input  start,
    input  angle_in,
    output ready_out,
    output cos_out
  );

endinterface

// File: rtl/taylor_series_cos_mul_shift.sv
// rtl/taylor_series_cos_mul_shift.sv - signed fixed-point multiply with rescale
//
// Purpose: p = (a * b) >>> IFRAC, truncated to IW bits (floor rounding).
// Ports:   a_i, b_i - signed IW-bit operands in Q.IFRAC
//          p_o      - signed IW-bit product in Q.IFRAC

module fxp_mul_shift #(
  parameter int IW    = 24,
  parameter int IFRAC = 20
) (
  input  logic signed [IW-1:0] a_i,
  input  logic signed [IW-1:0] b_i,
  output logic signed [IW-1:0] p_o
);

  logic signed [2*IW-1:0] prod;
  logic                   unused_bits;

  assign prod = (2*IW)'(a_i) * (2*IW)'(b_i);

  // Taking the slice above IFRAC is the arithmetic shift plus truncation;
  // overflow beyond IW bits wraps, which only happens for out-of-range angles.
  assign p_o = prod[IFRAC +: IW];

  assign unused_bits = ^{prod[2*IW-1:IFRAC+IW], prod[IFRAC-1:0]};

endmodule

// File: rtl/taylor_series_cos.sv
// rtl/taylor_series_cos.sv - iterative 8th-order Maclaurin cosine engine
//
// Purpose: cos(x) for an unsigned Q2.10 angle using one shared multiplier:
//          x^2 in SQUARE, then four Horner steps acc = Ck + x^2*acc.
//          Result is ready five edges after the edge that sampled start.
// Ports:   clock - rising-edge system clock
//          reset - asynchronous active-high reset
//          bus   - request bus (slave): start, angle_in, ready_out, cos_out

module taylor_series_cos
  import taylor_series_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  taylor_series_cos_if.slave  bus
);

  localparam int RSH = IFRAC - FRAC;  // internal -> I/O scaling shift

  state_t               state_q;
  logic [1:0]           step_q;
  logic signed [IW-1:0] x_q;
  logic signed [IW-1:0] x2_q;
  logic signed [IW-1:0] acc_q;
  logic [W-1:0]         cos_q;
  logic                 ready_q;

  logic signed [IW-1:0] mul_a;
  logic signed [IW-1:0] mul_b;
  logic signed [IW-1:0] mul_p;
  logic signed [IW-1:0] acc_d;
  logic signed [IW:0]   rnd_sum;
  logic signed [IW:0]   rnd_val;
  logic [W-1:0]         cos_d;

  // SQUARE uses x*x; HORNER uses x^2*acc.
  always_comb begin
    mul_a = x2_q;
    mul_b = acc_q;
    if (state_q == ST_SQUARE) begin
      mul_a = x_q;
      mul_b = x_q;
    end
  end

  fxp_mul_shift #(
    .IW    (IW),
    .IFRAC (IFRAC)
  ) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Next accumulator and its rounded, saturated I/O-format image. cos_d is
  // only captured on the last Horner step.
  always_comb begin
    acc_d   = horner_coef(step_q) + mul_p;
    rnd_sum = {acc_d[IW-1], acc_d} + (IW+1)'(1 << (RSH - 1));
    rnd_val = rnd_sum >>> RSH;
    if (rnd_val < 0) begin
      cos_d = '0;
    end else if (rnd_val > (IW+1)'(ONE_Q2_10)) begin
      cos_d = W'(ONE_Q2_10);
    end else begin
      cos_d = rnd_val[W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      x2_q    <= '0;
      acc_q   <= '0;
      cos_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            // Zero-extend Q2.10 into the signed Q.IFRAC datapath.
            x_q     <= {{(IW-W-RSH){1'b0}}, bus.angle_in, {RSH{1'b0}}};
            ready_q <= 1'b0;
            state_q <= ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          x2_q    <= mul_p;
          acc_q   <= C8;
          step_q  <= '0;
          state_q <= ST_HORNER;
        end
        ST_HORNER: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            cos_q   <= cos_d;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cos_out   = cos_q;
  assign bus.ready_out = ready_q;

endmodule

// File: tb/tb_taylor_series_cos.sv
// tb/tb_taylor_series_cos.sv - directed self-checking bench for taylor_series_cos

module tb_taylor_series_cos;
  import taylor_series_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   rise_cnt = 0;

  taylor_series_cos_if #(.W(W)) bus ();

  taylor_series_cos dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge bus.ready_out) rise_cnt++;

  // One request: start high for exactly one sampling edge (edge k).
  // lat counts edges after k until ready_out is seen high (bounded).
  task automatic run_req(input logic [W-1:0] a, output int lat, output logic rdy_k);
    @(posedge clock); #1;
    bus.angle_in = a;
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    rdy_k = bus.ready_out;
    lat = 0;
    while (bus.ready_out !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.angle_in = '0;
    #12;
    total++;
    if (bus.cos_out !== 12'd0) begin
      bad++; $display("FAIL reset_cos got=%0d want=0", bus.cos_out);
    end
    total++;
    if (bus.ready_out !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b want=0", bus.ready_out);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_zero;
    int lat; logic rdy_k;
    run_req(12'd0, lat, rdy_k);
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL zero_latency got=%0d want=5", lat);
    end
    total++;
    if (rdy_k !== 1'b0) begin
      bad++; $display("FAIL zero_ready_low_after_start got=%b want=0", rdy_k);
    end
    total++;
    if (bus.cos_out !== 12'd1024) begin
      bad++; $display("FAIL zero_cos got=%0d want=1024", bus.cos_out);
    end
    run_req(12'd1, lat, rdy_k);
    total++;
    if (bus.cos_out !== 12'd1024 || lat !== 5) begin
      bad++; $display("FAIL one_lsb_cos got=%0d lat=%0d want=1024 lat=5", bus.cos_out, lat);
    end
  endtask

  task automatic test_points;
    int lat; logic rdy_k;
    run_req(12'd512, lat, rdy_k);
    total++;
    if (bus.cos_out < 12'd898 || bus.cos_out > 12'd900 || lat !== 5) begin
      bad++; $display("FAIL cos_0p5 got=%0d lat=%0d want=899+/-1 lat=5", bus.cos_out, lat);
    end
    run_req(12'd1024, lat, rdy_k);
    total++;
    if (bus.cos_out < 12'd552 || bus.cos_out > 12'd554 || lat !== 5) begin
      bad++; $display("FAIL cos_1p0 got=%0d lat=%0d want=553+/-1 lat=5", bus.cos_out, lat);
    end
    run_req(12'd1608, lat, rdy_k);
    total++;
    if (bus.cos_out > 12'd1 || lat !== 5) begin
      bad++; $display("FAIL cos_1608 got=%0d lat=%0d want=0..1 lat=5", bus.cos_out, lat);
    end
  endtask

  task automatic test_busy_start;
    int lat;
    @(posedge clock); #1;
    bus.angle_in = 12'd512;
    bus.start    = 1'b1;
    @(posedge clock); #1;            // edge k sampled 512
    bus.angle_in = 12'd1024;         // new angle and start while busy
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      lat++;
    end
    bus.start = 1'b0;
    while (bus.ready_out !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    total++;
    if (lat !== 5) begin
      bad++; $display("FAIL busy_latency got=%0d want=5", lat);
    end
    total++;
    if (bus.cos_out < 12'd898 || bus.cos_out > 12'd900) begin
      bad++; $display("FAIL busy_result got=%0d want=899+/-1", bus.cos_out);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic rdy_k;
    run_req(12'd512, lat, rdy_k);
    @(posedge clock); #1;
    bus.angle_in = 12'd1024;
    bus.start    = 1'b1;
    @(posedge clock); #1;            // edge k
    bus.start = 1'b0;
    @(posedge clock);                // SQUARE -> HORNER
    @(posedge clock); #2;            // inside HORNER
    reset = 1'b1;
    #1;
    total++;
    if (bus.cos_out !== 12'd0 || bus.ready_out !== 1'b0) begin
      bad++; $display("FAIL reset_mid got cos=%0d rdy=%b want cos=0 rdy=0", bus.cos_out, bus.ready_out);
    end
    @(negedge clock);
    reset = 1'b0;
    run_req(12'd512, lat, rdy_k);
    total++;
    if (bus.cos_out < 12'd898 || bus.cos_out > 12'd900 || lat !== 5) begin
      bad++; $display("FAIL after_reset_cos got=%0d lat=%0d want=899+/-1 lat=5", bus.cos_out, lat);
    end
  endtask

  task automatic test_out_of_range_and_hold;
    int lat; logic rdy_k;
    run_req(12'd3000, lat, rdy_k);
    total++;
    if (bus.cos_out > 12'd1024 || lat !== 5 || bus.ready_out !== 1'b1) begin
      bad++; $display("FAIL out_of_range got=%0d lat=%0d rdy=%b want<=1024 lat=5 rdy=1", bus.cos_out, lat, bus.ready_out);
    end
    run_req(12'd1024, lat, rdy_k);
    for (int i = 0; i < 10; i++) begin
      bus.angle_in = 12'd200;        // ignored while start stays low
      @(posedge clock); #1;
      total++;
      if (bus.cos_out !== 12'd553 || bus.ready_out !== 1'b1) begin
        bad++; $display("FAIL hold_done cyc=%0d got cos=%0d rdy=%b want cos=553 rdy=1", i, bus.cos_out, bus.ready_out);
      end
    end
  endtask

  task automatic test_sweep;
    int   lat;
    logic rdy_k;
    int   exp_v;
    int   diff;
    int   rise0;
    real  sq_sum;
    rise0  = rise_cnt;
    sq_sum = 0.0;
    for (int a = 1; a <= 1608; a++) begin
      run_req(W'(a), lat, rdy_k);
      exp_v = $rtoi($floor(1024.0 * $cos(real'(a) / 1024.0) + 0.5));
      diff  = int'(bus.cos_out) - exp_v;
      sq_sum += real'(diff * diff);
      total++;
      if (diff > 2 || diff < -2 || lat !== 5) begin
        bad++; $display("FAIL sweep a=%0d got=%0d want=%0d+/-2 lat=%0d", a, bus.cos_out, exp_v, lat);
      end
      repeat (4) @(posedge clock);
    end
    total++;
    if (sq_sum / 1608.0 >= 1.0) begin
      bad++; $display("FAIL sweep_mse got=%f want<1.0", sq_sum / 1608.0);
    end
    total++;
    if (rise_cnt - rise0 !== 1608) begin
      bad++; $display("FAIL sweep_ready_edges got=%0d want=1608", rise_cnt - rise0);
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_points;
    test_busy_start;
    test_reset_mid;
    test_out_of_range_and_hold;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
